bus_slave_port: RTL
===================

BUS_SLAVE_PORT -- requirements
Module: bus_slave_port

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning data word width in bits.
REQ-002 The block SHALL have parameter MEM_ADDR_WIDTH, default 10, meaning local memory address width (depth 2**MEM_ADDR_WIDTH words).
REQ-003 The block SHALL have parameter ID_WIDTH, default 2, meaning width of the slave-select field in the bus address.
REQ-004 The block SHALL have parameter SLAVE_ID, default 0, meaning the value of the slave-select field this instance answers to.
REQ-005 The block SHALL have parameter READ_LATENCY, default 2, meaning wait cycles (>=1) between the last address bit and the first read-data bit.
REQ-006 The block SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-008 The block SHALL have port m_sel, input, 1, meaning the master holds the slave bus for a transaction while high.
REQ-009 The block SHALL have port m_svalid, input, 1, meaning m_sdata carries a valid frame bit this cycle.
REQ-010 The block SHALL have port m_sdata, input, 1, meaning the serial request bit from the master.
REQ-011 The block SHALL have port s_sdata, output, 1, meaning the serial read-data bit to the master.
REQ-012 The block SHALL have port s_svalid, output, 1, meaning s_sdata is valid this cycle.
REQ-013 The block SHALL have port s_ack, output, 1, meaning a one-cycle transaction-complete pulse.
REQ-014 The block SHALL have port s_busy, output, 1, meaning the block is serving an addressed transaction.

Function
REQ-015 The request frame SHALL be: rw bit first (1=write, 0=read); then ID_WIDTH+MEM_ADDR_WIDTH address bits, LSB first; the slave-select field is the top ID_WIDTH bits; for writes, DATA_WIDTH data bits follow, LSB first.
REQ-016 A frame bit SHALL be sampled only on a cycle with m_sel=1 and m_svalid=1; cycles with m_svalid=0 SHALL stall bit counting without loss of state.
REQ-017 The FSM SHALL have states IDLE, RX_ADDR, RX_WDATA, SKIP, WAIT, TX_RDATA and ACK.
REQ-018 Transitions: IDLE->RX_ADDR on the sampled rw bit; RX_ADDR->RX_WDATA (write) or WAIT (read) on the last address bit when the select field equals SLAVE_ID; RX_ADDR->SKIP on the last address bit on mismatch.
REQ-019 Further transitions: RX_WDATA->ACK on the last data bit; WAIT->TX_RDATA after READ_LATENCY cycles; TX_RDATA->ACK after DATA_WIDTH bits; ACK->IDLE after one cycle; SKIP->IDLE when m_sel=0.
REQ-020 Write: memory[addr] SHALL be updated in the cycle after the last data bit is sampled (ACK state), coincident with s_ack=1.
REQ-021 Read: s_svalid SHALL be high for exactly DATA_WIDTH consecutive cycles, carrying memory[addr] LSB first, starting READ_LATENCY cycles after the last address bit; s_ack SHALL pulse in the cycle after the last data bit.
REQ-022 s_sdata SHALL be 0 whenever s_svalid=0.
REQ-023 s_busy SHALL be 1 in RX_WDATA, WAIT, TX_RDATA and ACK, and 0 otherwise; SKIP SHALL never drive s_svalid, s_ack or s_busy.
REQ-024 If m_sel falls in any state other than IDLE or ACK, the FSM SHALL return to IDLE next cycle, with no memory write, no s_ack and s_svalid=0.
REQ-025 m_svalid during WAIT, TX_RDATA or ACK SHALL be ignored.
REQ-026 Following ACK, a new frame SHALL NOT be sampled until m_sel has been observed low for at least one cycle.

Reset
REQ-027 While reset=1, the block SHALL enter IDLE with s_sdata=0, s_svalid=0, s_ack=0 and s_busy=0, clearing all counters and shift registers.
REQ-028 Reset asserted mid-transaction SHALL abort it with no memory write; memory contents SHALL NOT be reset.

Verification
REQ-029 Write then read with SLAVE_ID=0: write 0xA5 to address 0x005, then read 0x005 -> write s_ack at frame end+1; read s_svalid 8 cycles, serial bits 1,0,1,0,0,1,0,1; first bit 2 cycles after the last address bit.
REQ-030 Frame with select field 2 (SLAVE_ID=0) -> s_busy, s_svalid and s_ack stay 0; a subsequent read of the same local address returns its prior value.
REQ-031 Write frame with m_svalid deasserted for 3 cycles between data bits -> correct value stored; s_ack delayed by exactly 3 cycles.
REQ-032 m_sel dropped after 4 of 8 write-data bits -> no s_ack; a read of that address returns its old value.
REQ-033 reset pulsed for 1 cycle during TX_RDATA -> s_svalid=0 and s_busy=0 on the next cycle; the next full read completes normally.

Source files
------------

// File: rtl/bus_slave_port.sv
// Serial bus slave port: decodes rw/address/data frames from a master and
// serves reads and writes against a local word memory.
module bus_slave_port #(
  parameter int DATA_WIDTH     = 8,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int ID_WIDTH       = 2,
  parameter int SLAVE_ID       = 0,
  parameter int READ_LATENCY   = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic m_sel,
  input  logic m_svalid,
  input  logic m_sdata,
  output logic s_sdata,
  output logic s_svalid,
  output logic s_ack,
  output logic s_busy
);

  localparam int AW      = ID_WIDTH + MEM_ADDR_WIDTH;
  localparam int MAX_AD  = (AW > DATA_WIDTH) ? AW : DATA_WIDTH;
  localparam int CNT_MAX = (MAX_AD > READ_LATENCY) ? MAX_AD : READ_LATENCY;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, RX_ADDR, RX_WDATA, SKIP, WAIT, TX_RDATA, ACK
  } state_t;

  state_t                  state, state_next;
  logic [CW-1:0]           cnt;
  logic [AW-1:0]           addr_sr;
  logic [AW-1:0]           addr_next;
  logic [DATA_WIDTH-1:0]   wdata_sr;
  logic [DATA_WIDTH-1:0]   tx_sr;
  logic                    is_write;
  logic                    wait_release;
  logic                    sample;
  logic                    counting;
  logic [DATA_WIDTH-1:0]   mem [2**MEM_ADDR_WIDTH];

  assign sample    = m_sel & m_svalid;
  assign addr_next = {m_sdata, addr_sr[AW-1:1]};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Losing m_sel aborts every phase except the final ACK cycle.
  always_comb begin
    state_next = state;
    counting   = 1'b0;
    case (state)
      IDLE: begin
        if (sample && !wait_release) state_next = RX_ADDR;
      end
      RX_ADDR: begin
        counting = sample;
        if (!m_sel) state_next = IDLE;
        else if (sample && cnt == CW'(AW - 1)) begin
          if (addr_next[AW-1 -: ID_WIDTH] == ID_WIDTH'(SLAVE_ID))
            state_next = is_write ? RX_WDATA : WAIT;
          else
            state_next = SKIP;
        end
      end
      RX_WDATA: begin
        counting = sample;
        if (!m_sel) state_next = IDLE;
        else if (sample && cnt == CW'(DATA_WIDTH - 1)) state_next = ACK;
      end
      SKIP: begin
        if (!m_sel) state_next = IDLE;
      end
      WAIT: begin
        counting = 1'b1;
        if (!m_sel) state_next = IDLE;
        else if (cnt == CW'(READ_LATENCY - 1)) state_next = TX_RDATA;
      end
      TX_RDATA: begin
        counting = 1'b1;
        if (!m_sel) state_next = IDLE;
        else if (cnt == CW'(DATA_WIDTH - 1)) state_next = ACK;
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      addr_sr      <= '0;
      wdata_sr     <= '0;
      tx_sr        <= '0;
      is_write     <= 1'b0;
      wait_release <= 1'b0;
    end else begin
      if (state_next != state) cnt <= '0;
      else if (counting)       cnt <= cnt + 1'b1;

      if (state == IDLE && sample && !wait_release) is_write <= m_sdata;
      if (state == RX_ADDR && sample)  addr_sr  <= addr_next;
      if (state == RX_WDATA && sample) wdata_sr <= {m_sdata, wdata_sr[DATA_WIDTH-1:1]};

      // The memory word is fetched throughout WAIT, so any latency >= 1 works.
      if (state == WAIT)          tx_sr <= mem[addr_sr[MEM_ADDR_WIDTH-1:0]];
      else if (state == TX_RDATA) tx_sr <= tx_sr >> 1;

      if (state == ACK)  wait_release <= 1'b1;
      else if (!m_sel)   wait_release <= 1'b0;
    end
  end

  // Memory is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (!reset && state == ACK && is_write)
      mem[addr_sr[MEM_ADDR_WIDTH-1:0]] <= wdata_sr;
  end

  always_comb begin
    s_svalid = !reset && state == TX_RDATA;
    s_sdata  = s_svalid && tx_sr[0];
    s_ack    = !reset && state == ACK;
    s_busy   = !reset && (state == RX_WDATA || state == WAIT ||
                          state == TX_RDATA || state == ACK);
  end

endmodule
